// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared widths, defaults and constants for the register file writeback path.
package rf_writeback_arbiter_pkg;

    localparam int NUM_REQ_DEF     = 3;
    localparam int RF_ADDR_LEN_DEF = 5;
    localparam int RF_DATA_LEN_DEF = 32;

    // x0 is hardwired to zero; writes to it are accepted but dropped
    localparam int X0_ADDR = 0;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_writeback_arbiter_if.sv
// Writeback request bus plus the register file write port it feeds.
interface rf_writeback_arbiter_if
    import rf_writeback_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int RF_ADDR_LEN = RF_ADDR_LEN_DEF,
    parameter int RF_DATA_LEN = RF_DATA_LEN_DEF
);

    logic                           stall;
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*RF_ADDR_LEN-1:0] req_addr;
    logic [NUM_REQ*RF_DATA_LEN-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           w_en;
    logic [RF_ADDR_LEN-1:0]         rd_addr;
    logic [RF_DATA_LEN-1:0]         rd_write_data;

    modport master (
        output stall, req_valid, req_addr, req_data,
        input  req_ready, w_en, rd_addr, rd_write_data
    );

    modport slave (
        input  stall, req_valid, req_addr, req_data,
        output req_ready, w_en, rd_addr, rd_write_data
    );

endinterface

// File: rtl/rf_writeback_arbiter_rr_priority_arbiter.sv
// Combinational rotating-priority picker; the pointer register lives in the caller.
module rr_priority_arbiter
    import rf_writeback_arbiter_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] win_idx,
    output logic          any_grant
);

    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        win_idx   = '0;
        any_grant = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (enable && !any_grant && req[j]) begin
                any_grant = 1'b1;
                grant[j]  = 1'b1;
                win_idx   = PW'(j);
            end
        end
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Round-robin arbitration of writeback sources onto the single RF write port.
module rf_writeback_arbiter
    import rf_writeback_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int RF_ADDR_LEN = RF_ADDR_LEN_DEF,
    parameter int RF_DATA_LEN = RF_DATA_LEN_DEF
) (
    input logic clk,
    input logic rst,
    rf_writeback_arbiter_if.slave bus
);

    localparam int PW = idx_width(NUM_REQ);

    logic [PW-1:0]          ptr;
    logic [PW-1:0]          ptr_nxt;
    logic [PW-1:0]          win_idx;
    logic [NUM_REQ-1:0]     grant;
    logic                   any_grant;
    logic                   arb_en;
    logic [RF_ADDR_LEN-1:0] addr_arr [NUM_REQ];
    logic [RF_DATA_LEN-1:0] data_arr [NUM_REQ];
    logic [RF_ADDR_LEN-1:0] win_addr;
    logic [RF_DATA_LEN-1:0] win_data;
    logic                   w_en_q;
    logic [RF_ADDR_LEN-1:0] rd_addr_q;
    logic [RF_DATA_LEN-1:0] rd_data_q;

    // Reset masks ready so nothing is handed off while state is clearing
    assign arb_en = !bus.stall && !rst;

    rr_priority_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_arb (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .enable    (arb_en),
        .grant     (grant),
        .win_idx   (win_idx),
        .any_grant (any_grant)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = bus.req_addr[i*RF_ADDR_LEN +: RF_ADDR_LEN];
            data_arr[i] = bus.req_data[i*RF_DATA_LEN +: RF_DATA_LEN];
        end
    end

    assign win_addr = addr_arr[win_idx];
    assign win_data = data_arr[win_idx];

    assign ptr_nxt = (int'(win_idx) == NUM_REQ - 1) ? '0
                   : win_idx + PW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            w_en_q    <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            w_en_q <= 1'b0;
            if (any_grant) begin
                ptr <= ptr_nxt;
                if (win_addr != RF_ADDR_LEN'(X0_ADDR)) begin
                    w_en_q    <= 1'b1;
                    rd_addr_q <= win_addr;
                    rd_data_q <= win_data;
                end
            end
        end
    end

    assign bus.req_ready     = grant;
    assign bus.w_en          = w_en_q;
    assign bus.rd_addr       = rd_addr_q;
    assign bus.rd_write_data = rd_data_q;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed vector bench for the writeback arbiter.
module tb_rf_writeback_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct {
        logic          stall;
        logic [N-1:0]  valid;
        logic [N*AW-1:0] addr;
        logic [N*DW-1:0] data;
        logic [N-1:0]  exp_ready;
        logic          exp_wen;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
    } vec_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    vec_t vecs [$];

    rf_writeback_arbiter_if #(
        .NUM_REQ     (N),
        .RF_ADDR_LEN (AW),
        .RF_DATA_LEN (DW)
    ) bus ();

    rf_writeback_arbiter #(
        .NUM_REQ     (N),
        .RF_ADDR_LEN (AW),
        .RF_DATA_LEN (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic st, input logic [N-1:0] v,
        input logic [AW-1:0] a0, a1, a2,
        input logic [DW-1:0] d0, d1, d2,
        input logic [N-1:0] er, input logic ew,
        input logic [AW-1:0] ea, input logic [DW-1:0] ed);
        vec_t r;
        r.stall     = st;
        r.valid     = v;
        r.addr      = {a2, a1, a0};
        r.data      = {d2, d1, d0};
        r.exp_ready = er;
        r.exp_wen   = ew;
        r.exp_addr  = ea;
        r.exp_data  = ed;
        return r;
    endfunction

    task automatic drive(input logic st, input logic [N-1:0] v,
                         input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
        bus.stall     = st;
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.req_data  = d;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        drive(1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA});

        // round robin
        vecs.push_back(mk(0, 3'b111, 1, 2, 3, 'hA, 'hB, 'hC, 3'b001, 1, 1, 'hA));
        vecs.push_back(mk(0, 3'b111, 1, 2, 3, 'hA, 'hB, 'hC, 3'b010, 1, 2, 'hB));
        vecs.push_back(mk(0, 3'b111, 1, 2, 3, 'hA, 'hB, 'hC, 3'b100, 1, 3, 'hC));
        vecs.push_back(mk(0, 3'b111, 1, 2, 3, 'hA, 'hB, 'hC, 3'b001, 1, 1, 'hA));
        // single source
        vecs.push_back(mk(0, 3'b010, 1, 5, 3, 'hA, 'hDEADBEEF, 'hC,
                          3'b010, 1, 5, 'hDEADBEEF));
        vecs.push_back(mk(0, 3'b010, 1, 5, 3, 'hA, 'hDEADBEEF, 'hC,
                          3'b010, 1, 5, 'hDEADBEEF));
        vecs.push_back(mk(0, 3'b010, 1, 5, 3, 'hA, 'hDEADBEEF, 'hC,
                          3'b010, 1, 5, 'hDEADBEEF));
        // x0 discard, then ptr=1 shows as requester 1 winning
        vecs.push_back(mk(0, 3'b001, 0, 5, 3, 'hFFFFFFFF, 'hDEADBEEF, 'hC,
                          3'b001, 0, 5, 'hDEADBEEF));
        vecs.push_back(mk(0, 3'b111, 1, 2, 3, 'hA, 'hB, 'hC, 3'b010, 1, 2, 'hB));
        // stall three cycles, ptr held at 2
        vecs.push_back(mk(1, 3'b101, 1, 2, 3, 'hA, 'hB, 'hC, 3'b000, 0, 2, 'hB));
        vecs.push_back(mk(1, 3'b101, 1, 2, 3, 'hA, 'hB, 'hC, 3'b000, 0, 2, 'hB));
        vecs.push_back(mk(1, 3'b101, 1, 2, 3, 'hA, 'hB, 'hC, 3'b000, 0, 2, 'hB));
        vecs.push_back(mk(0, 3'b101, 1, 2, 3, 'hA, 'hB, 'hC, 3'b100, 1, 3, 'hC));
        vecs.push_back(mk(0, 3'b101, 1, 2, 3, 'hA, 'hB, 'hC, 3'b001, 1, 1, 'hA));
        vecs.push_back(mk(0, 3'b101, 1, 2, 3, 'hA, 'hB, 'hC, 3'b100, 1, 3, 'hC));
        // fairness: req0 steady, req2 joins
        vecs.push_back(mk(0, 3'b001, 1, 2, 3, 'hA, 'hB, 'hC, 3'b001, 1, 1, 'hA));
        vecs.push_back(mk(0, 3'b101, 1, 2, 3, 'hA, 'hB, 'hC, 3'b100, 1, 3, 'hC));
        // idle holds outputs
        vecs.push_back(mk(0, 3'b000, 1, 2, 3, 'hA, 'hB, 'hC, 3'b000, 0, 3, 'hC));
        // same destination, serialized in grant order
        vecs.push_back(mk(0, 3'b011, 7, 7, 3, 'h11, 'h22, 'hC, 3'b001, 1, 7, 'h11));
        vecs.push_back(mk(0, 3'b010, 7, 7, 3, 'h11, 'h22, 'hC, 3'b010, 1, 7, 'h22));

        // reset state
        @(posedge clk);
        #1;
        chk("rst_ready", DW'(bus.req_ready), '0);
        chk("rst_wen",   DW'(bus.w_en), '0);
        chk("rst_addr",  DW'(bus.rd_addr), '0);
        chk("rst_data",  bus.rd_write_data, '0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[k]) begin
            if (k != 0) @(negedge clk);
            drive(vecs[k].stall, vecs[k].valid, vecs[k].addr, vecs[k].data);
            #1;
            chk($sformatf("v%0d_ready", k), DW'(bus.req_ready),
                DW'(vecs[k].exp_ready));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wen", k), DW'(bus.w_en), DW'(vecs[k].exp_wen));
            chk($sformatf("v%0d_addr", k), DW'(bus.rd_addr),
                DW'(vecs[k].exp_addr));
            chk($sformatf("v%0d_data", k), bus.rd_write_data, vecs[k].exp_data);
        end

        // asynchronous reset mid-stream clears outputs without a clock edge
        @(negedge clk);
        drive(1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA});
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", DW'(bus.req_ready), '0);
        chk("mid_rst_wen",   DW'(bus.w_en), '0);
        chk("mid_rst_addr",  DW'(bus.rd_addr), '0);
        chk("mid_rst_data",  bus.rd_write_data, '0);
        @(posedge clk);
        #1;
        chk("rst_edge_wen", DW'(bus.w_en), '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", DW'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("post_rst_wen",  DW'(bus.w_en), 32'h1);
        chk("post_rst_addr", DW'(bus.rd_addr), 32'h1);
        chk("post_rst_data", bus.rd_write_data, 32'hA);
        @(negedge clk);
        #1;
        chk("post_rst_ready2", DW'(bus.req_ready), 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
